// File: rtl/draw_cmd_if.sv
// rtl/draw_cmd_if.sv - command stream and processor issue signals of draw_cmd_scheduler
interface draw_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [35:0] cmd_data;
    logic [35:0] instr_out;
    logic        instr_valid;
    logic        draw_done;

    modport master (
        output cmd_valid,
        output cmd_data,
        output draw_done,
        input  cmd_ready,
        input  instr_out,
        input  instr_valid
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  draw_done,
        output cmd_ready,
        output instr_out,
        output instr_valid
    );
endinterface

// File: rtl/draw_cmd_scheduler.sv
// rtl/draw_cmd_scheduler.sv - draw command FIFO and issue sequencer; DRAW_CMD_TIMEOUT_EN adds the WAIT abort timer
module draw_cmd_scheduler #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    draw_cmd_if.slave        bus,
    input  logic             flush,
    output logic             busy,
    output logic [AW:0]      fifo_count,
    output logic             timeout_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    if ((1 << AW) != DEPTH) begin : g_bad_depth
        $error("DEPTH must equal 2**AW");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must fit the 16-bit wait counter");
    end

    logic [1:0]    state;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [35:0]   head;
    logic [2:0]    head_op;
    logic          head_long;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full      = (fifo_count == (AW+1)'(DEPTH));
    assign empty     = (fifo_count == '0);
    assign bus.cmd_ready = reset & ~full & ~flush;
    assign push      = bus.cmd_valid & bus.cmd_ready;
    assign pop       = (state == S_IDLE) & ~empty & ~flush;
    assign head      = mem[rd_ptr];
    assign head_op   = head[35:33];
    assign head_long = (head_op == 3'b110) || (head_op == 3'b101);
    assign busy      = (state != S_IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

`ifdef DRAW_CMD_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;
    logic        err_q;
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            bus.instr_out   <= '0;
            bus.instr_valid <= 1'b0;
`ifdef DRAW_CMD_TIMEOUT_EN
            wait_cnt        <= '0;
            err_q           <= 1'b0;
`endif
        end else if (flush) begin
            state           <= S_IDLE;
            bus.instr_out   <= '0;
            bus.instr_valid <= 1'b0;
`ifdef DRAW_CMD_TIMEOUT_EN
            wait_cnt        <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            bus.instr_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // opcodes 0xx are popped by the FIFO logic and simply never issued
                    if (!empty && head_op[2]) begin
                        bus.instr_out   <= head;
                        bus.instr_valid <= 1'b1;
                        state           <= head_long ? S_WAIT : S_GAP;
`ifdef DRAW_CMD_TIMEOUT_EN
                        wait_cnt        <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.draw_done) begin
                        state <= S_GAP;
`ifdef DRAW_CMD_TIMEOUT_EN
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_GAP;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    bus.instr_out <= '0;
                    state         <= S_IDLE;
                end
                default: begin
                    bus.instr_out <= '0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
